// File: rtl/controlador_cache_pkg.sv
// controlador_cache_pkg
// Shared types and constants for the two-line write-back L1 controller:
// address/data widths, line count, FSM state encoding, the cache line record
// and a helper that builds a freshly installed line.
package controlador_cache_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int NUM_LINES = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_FILL       = 3'd3,
    ST_RESPOND    = 3'd4,
    ST_FLUSH_SCAN = 3'd5,
    ST_FLUSH_WB   = 3'd6
  } estado_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } linha_t;

  // Builds a valid line; the tag is the full address because a line holds one word.
  function automatic linha_t nova_linha(input logic              dirty,
                                        input logic [ADDR_W-1:0] tag,
                                        input logic [DATA_W-1:0] data);
    linha_t l;
    l.valid = 1'b1;
    l.dirty = dirty;
    l.tag   = tag;
    l.data  = data;
    return l;
  endfunction

endpackage

// File: rtl/controlador_cache_linhas.sv
// linhas_cache
// Two-line fully associative store plus the single-bit LRU register.
// Lookup is combinational; all updates are registered and applied on the
// rising edge when their enable is high.
// Ports:
//   clock, resetn      clock, synchronous active-low reset
//   lookup_address     address compared against every valid tag
//   hit, hit_idx       a valid line matches, and which one
//   victim_idx         lowest-index invalid line, else the LRU line
//   linhas             current contents of every line
//   upd_en/idx/linha   overwrite a whole line
//   clr_en/idx         clear one line's dirty bit
//   touch_en/idx       make a line most recently used
module linhas_cache
  import controlador_cache_pkg::*;
(
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [ADDR_W-1:0]           lookup_address,
  output logic                        hit,
  output logic                        hit_idx,
  output logic                        victim_idx,
  output linha_t [NUM_LINES-1:0]      linhas,
  input  logic                        upd_en,
  input  logic                        upd_idx,
  input  linha_t                      upd_linha,
  input  logic                        clr_en,
  input  logic                        clr_idx,
  input  logic                        touch_en,
  input  logic                        touch_idx
);

  linha_t [NUM_LINES-1:0] linhas_r;
  logic                   lru_r;
  logic [NUM_LINES-1:0]   match_s;

  assign linhas = linhas_r;

  // Tag match per line; tags are unique, so at most one bit is set.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      match_s[i] = linhas_r[i].valid && (linhas_r[i].tag == lookup_address);
    end
    hit     = |match_s;
    hit_idx = match_s[1];
  end

  // Victim choice: fill empty lines first, otherwise evict the LRU line.
  always_comb begin
    if (!linhas_r[0].valid) begin
      victim_idx = 1'b0;
    end else if (!linhas_r[1].valid) begin
      victim_idx = 1'b1;
    end else begin
      victim_idx = lru_r;
    end
  end

  // Line and LRU state; a full-line update issued with a dirty clear wins.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      linhas_r <= '0;
      lru_r    <= 1'b0;
    end else begin
      if (clr_en) begin
        linhas_r[clr_idx].dirty <= 1'b0;
      end
      if (upd_en) begin
        linhas_r[upd_idx] <= upd_linha;
      end
      if (touch_en) begin
        lru_r <= ~touch_idx;
      end
    end
  end

endmodule

// File: rtl/controlador_cache.sv
// controlador_cache
// L1 controller between a single requester and a req/ack RAM. Resolves
// hit/miss, writes back dirty victims, fills read misses, allocates write
// misses without fetching, and walks both lines on a flush command.
// Ports:
//   clock, resetn                       clock, synchronous active-low reset
//   cpu_req/write/flush/address/dataIn  request side, sampled only in IDLE
//   cpu_ready, cpu_dataOut, hit         one-cycle completion with result
//   busy                                high whenever the FSM is not IDLE
//   ram_req/write/address/dataIn        RAM request, held until ram_ack
//   ram_dataOut, ram_ack                RAM response
module controlador_cache
  import controlador_cache_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic              cpu_flush,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_dataIn,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_dataOut,
  output logic              hit,
  output logic              busy,
  output logic              ram_req,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut,
  input  logic              ram_ack
);

  localparam logic [1:0] FLUSH_FIM = 2'(NUM_LINES);

  estado_t                estado_r;
  logic                   write_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      din_r;
  logic [DATA_W-1:0]      data_r;
  logic                   hit_r;
  logic                   victim_r;
  logic [1:0]             flush_idx_r;

  logic                   upd_en_r;
  logic                   upd_idx_r;
  linha_t                 upd_linha_r;
  logic                   clr_en_r;
  logic                   clr_idx_r;
  logic                   touch_en_r;
  logic                   touch_idx_r;

  logic                   hit_s;
  logic                   hit_idx_s;
  logic                   victim_idx_s;
  linha_t [NUM_LINES-1:0] linhas_s;
  linha_t                 victim_linha_s;
  linha_t                 flush_linha_s;

  assign victim_linha_s = linhas_s[victim_idx_s];
  assign flush_linha_s  = linhas_s[flush_idx_r[0]];

  linhas_cache u_linhas (
    .clock          (clock),
    .resetn         (resetn),
    .lookup_address (addr_r),
    .hit            (hit_s),
    .hit_idx        (hit_idx_s),
    .victim_idx     (victim_idx_s),
    .linhas         (linhas_s),
    .upd_en         (upd_en_r),
    .upd_idx        (upd_idx_r),
    .upd_linha      (upd_linha_r),
    .clr_en         (clr_en_r),
    .clr_idx        (clr_idx_r),
    .touch_en       (touch_en_r),
    .touch_idx      (touch_idx_r)
  );

  // Controller FSM. Store updates are one-cycle strobes that land on the
  // following edge; every path passes through RESPOND before IDLE, so the
  // next lookup always sees the updated lines.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      estado_r    <= ST_IDLE;
      write_r     <= 1'b0;
      addr_r      <= '0;
      din_r       <= '0;
      data_r      <= '0;
      hit_r       <= 1'b0;
      victim_r    <= 1'b0;
      flush_idx_r <= 2'd0;
      upd_en_r    <= 1'b0;
      upd_idx_r   <= 1'b0;
      upd_linha_r <= '0;
      clr_en_r    <= 1'b0;
      clr_idx_r   <= 1'b0;
      touch_en_r  <= 1'b0;
      touch_idx_r <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_dataOut <= '0;
      hit         <= 1'b0;
      busy        <= 1'b0;
      ram_req     <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_dataIn  <= '0;
    end else begin
      cpu_ready  <= 1'b0;
      upd_en_r   <= 1'b0;
      clr_en_r   <= 1'b0;
      touch_en_r <= 1'b0;
      case (estado_r)
        ST_IDLE: begin
          if (cpu_flush) begin
            flush_idx_r <= 2'd0;
            hit_r       <= 1'b0;
            busy        <= 1'b1;
            estado_r    <= ST_FLUSH_SCAN;
          end else if (cpu_req) begin
            write_r  <= cpu_write;
            addr_r   <= cpu_address;
            din_r    <= cpu_dataIn;
            busy     <= 1'b1;
            estado_r <= ST_LOOKUP;
          end else begin
            estado_r <= ST_IDLE;
          end
        end

        ST_LOOKUP: begin
          victim_r <= victim_idx_s;
          if (hit_s) begin
            hit_r       <= 1'b1;
            touch_en_r  <= 1'b1;
            touch_idx_r <= hit_idx_s;
            if (write_r) begin
              upd_en_r    <= 1'b1;
              upd_idx_r   <= hit_idx_s;
              upd_linha_r <= nova_linha(1'b1, addr_r, din_r);
            end else begin
              data_r <= linhas_s[hit_idx_s].data;
            end
            estado_r <= ST_RESPOND;
          end else begin
            hit_r <= 1'b0;
            if (victim_linha_s.valid && victim_linha_s.dirty) begin
              ram_req     <= 1'b1;
              ram_write   <= 1'b1;
              ram_address <= victim_linha_s.tag;
              ram_dataIn  <= victim_linha_s.data;
              estado_r    <= ST_WRITEBACK;
            end else if (write_r) begin
              upd_en_r    <= 1'b1;
              upd_idx_r   <= victim_idx_s;
              upd_linha_r <= nova_linha(1'b1, addr_r, din_r);
              touch_en_r  <= 1'b1;
              touch_idx_r <= victim_idx_s;
              estado_r    <= ST_RESPOND;
            end else begin
              ram_req     <= 1'b1;
              ram_write   <= 1'b0;
              ram_address <= addr_r;
              ram_dataIn  <= '0;
              estado_r    <= ST_FILL;
            end
          end
        end

        ST_WRITEBACK: begin
          if (ram_req && ram_ack) begin
            ram_req <= 1'b0;
            if (write_r) begin
              // The install overwrites the whole line, so the dirty clear is implied.
              upd_en_r    <= 1'b1;
              upd_idx_r   <= victim_r;
              upd_linha_r <= nova_linha(1'b1, addr_r, din_r);
              touch_en_r  <= 1'b1;
              touch_idx_r <= victim_r;
              estado_r    <= ST_RESPOND;
            end else begin
              clr_en_r  <= 1'b1;
              clr_idx_r <= victim_r;
              estado_r  <= ST_FILL;
            end
          end else begin
            estado_r <= ST_WRITEBACK;
          end
        end

        ST_FILL: begin
          // Coming from WRITEBACK the request is idle for one cycle before the read.
          if (!ram_req) begin
            ram_req     <= 1'b1;
            ram_write   <= 1'b0;
            ram_address <= addr_r;
            ram_dataIn  <= '0;
            estado_r    <= ST_FILL;
          end else if (ram_ack) begin
            ram_req     <= 1'b0;
            data_r      <= ram_dataOut;
            upd_en_r    <= 1'b1;
            upd_idx_r   <= victim_r;
            upd_linha_r <= nova_linha(1'b0, addr_r, ram_dataOut);
            touch_en_r  <= 1'b1;
            touch_idx_r <= victim_r;
            estado_r    <= ST_RESPOND;
          end else begin
            estado_r <= ST_FILL;
          end
        end

        ST_RESPOND: begin
          cpu_ready   <= 1'b1;
          hit         <= hit_r;
          cpu_dataOut <= data_r;
          busy        <= 1'b0;
          estado_r    <= ST_IDLE;
        end

        ST_FLUSH_SCAN: begin
          if (flush_idx_r == FLUSH_FIM) begin
            estado_r <= ST_RESPOND;
          end else if (flush_linha_s.valid && flush_linha_s.dirty) begin
            ram_req     <= 1'b1;
            ram_write   <= 1'b1;
            ram_address <= flush_linha_s.tag;
            ram_dataIn  <= flush_linha_s.data;
            estado_r    <= ST_FLUSH_WB;
          end else begin
            flush_idx_r <= flush_idx_r + 2'd1;
            estado_r    <= ST_FLUSH_SCAN;
          end
        end

        ST_FLUSH_WB: begin
          if (ram_req && ram_ack) begin
            ram_req     <= 1'b0;
            clr_en_r    <= 1'b1;
            clr_idx_r   <= flush_idx_r[0];
            flush_idx_r <= flush_idx_r + 2'd1;
            estado_r    <= ST_FLUSH_SCAN;
          end else begin
            estado_r <= ST_FLUSH_WB;
          end
        end

        default: begin
          estado_r <= ST_IDLE;
          busy     <= 1'b0;
          ram_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_cache.sv
// tb_controlador_cache
// Self-checking bench: a RAM responder with configurable ack delay, a
// behavioural two-line LRU cache model with a shadow memory, directed
// scenarios followed by randomized traffic.
module tb_controlador_cache;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } ram_tx_t;

  logic       clock;
  logic       resetn;
  logic       cpu_req;
  logic       cpu_write;
  logic       cpu_flush;
  logic [7:0] cpu_address;
  logic [7:0] cpu_dataIn;
  logic       cpu_ready;
  logic [7:0] cpu_dataOut;
  logic       hit;
  logic       busy;
  logic       ram_req;
  logic       ram_write;
  logic [7:0] ram_address;
  logic [7:0] ram_dataIn;
  logic [7:0] ram_dataOut;
  logic       ram_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  ram_tx_t    exp_q [$];
  ram_tx_t    obs_q [$];
  int         ack_delay;
  bit         spur_en;

  // reference model state
  logic       m_valid [2];
  logic       m_dirty [2];
  logic [7:0] m_tag   [2];
  logic [7:0] m_data  [2];
  int         m_lru;
  logic [7:0] last_rd;

  controlador_cache dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_flush   (cpu_flush),
    .cpu_address (cpu_address),
    .cpu_dataIn  (cpu_dataIn),
    .cpu_ready   (cpu_ready),
    .cpu_dataOut (cpu_dataOut),
    .hit         (hit),
    .busy        (busy),
    .ram_req     (ram_req),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .ram_ack     (ram_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic ram_tx_t mk_tx(input logic w, input logic [7:0] a, input logic [7:0] d);
    ram_tx_t t;
    t.w = w; t.a = a; t.d = d;
    return t;
  endfunction

  // RAM responder: captures a request, holds it for ack_delay cycles
  // (checking the request stays stable), then acks for one cycle.
  initial begin : ram_model
    ram_tx_t cap;
    int      cnt;
    bit      in_tx;
    ram_ack = 1'b0; ram_dataOut = 8'h00; in_tx = 1'b0; cnt = 0; cap = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        in_tx = 1'b0; ram_ack = 1'b0;
      end else if (ram_ack) begin
        ram_ack = 1'b0; in_tx = 1'b0;
      end else if (in_tx || ram_req) begin
        if (in_tx) begin
          verifica("ram_hold", 32'({ram_req, ram_write, ram_address, ram_dataIn}),
                   32'({1'b1, cap.w, cap.a, cap.d}));
        end else begin
          cap = mk_tx(ram_write, ram_address, ram_dataIn);
          in_tx = 1'b1; cnt = ack_delay;
        end
        if (cnt == 0) begin
          ram_ack = 1'b1;
          if (cap.w) begin
            mem[cap.a] = cap.d;
            obs_q.push_back(cap);
          end else begin
            ram_dataOut = mem[cap.a];
            obs_q.push_back(mk_tx(1'b0, cap.a, mem[cap.a]));
          end
        end else begin
          cnt--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        ram_ack = 1'b1;          // stray ack with no request outstanding
        ram_dataOut = 8'($urandom);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 8'h00; m_data[i] = 8'h00;
    end
    m_lru = 0; last_rd = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                              output logic exp_hit);
    int way;
    way = -1;
    exp_q.delete();
    for (int i = 0; i < 2; i++) if (m_valid[i] && m_tag[i] == a) way = i;
    exp_hit = (way >= 0);
    if (way < 0) begin
      if (!m_valid[0]) way = 0;
      else if (!m_valid[1]) way = 1;
      else way = m_lru;
      if (m_valid[way] && m_dirty[way]) begin
        exp_q.push_back(mk_tx(1'b1, m_tag[way], m_data[way]));
        shadow[m_tag[way]] = m_data[way];
      end
      m_valid[way] = 1'b1; m_tag[way] = a;
      if (wr) begin
        m_data[way] = d; m_dirty[way] = 1'b1;
      end else begin
        exp_q.push_back(mk_tx(1'b0, a, shadow[a]));
        m_data[way] = shadow[a]; m_dirty[way] = 1'b0;
      end
    end else if (wr) begin
      m_data[way] = d; m_dirty[way] = 1'b1;
    end
    if (!wr) last_rd = m_data[way];
    m_lru = (way == 0) ? 1 : 0;
  endtask

  task automatic model_flush();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_q.push_back(mk_tx(1'b1, m_tag[i], m_data[i]));
        shadow[m_tag[i]] = m_data[i];
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d; shadow[a] = d;
  endtask

  // Waits for cpu_ready; k counts rising edges after the accepting edge.
  task automatic wait_ready(output int k);
    bit got;
    got = 1'b0; k = 0;
    while (!got && k < 200) begin
      @(posedge clock); k++;
      @(negedge clock);
      if (cpu_ready) got = 1'b1;
    end
    verifica("ready_seen", 32'(got), 32'd1);
  endtask

  task automatic compare_ram();
    verifica("ram_ntx", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      verifica("ram_tx", 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic finish_op(input logic exp_hit, input bit chk_lat, input int k);
    verifica("hit", 32'(hit), 32'(exp_hit));
    verifica("dout", 32'(cpu_dataOut), 32'(last_rd));
    verifica("busy_lo", 32'(busy), 32'd0);
    if (chk_lat) verifica("hit_lat", 32'(k), 32'd2);
    compare_ram();
    @(posedge clock); @(negedge clock);
    verifica("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic exp_hit;
    int   k;
    model_access(wr, a, d, exp_hit);
    obs_q.delete();
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = wr; cpu_address = a; cpu_dataIn = d;
    @(posedge clock);
    @(negedge clock);
    cpu_req = 1'b0;
    verifica("busy_hi", 32'(busy), 32'd1);
    wait_ready(k);
    finish_op(exp_hit, exp_hit, k);
  endtask

  task automatic flush_op(input logic with_req, input logic [7:0] a, input logic [7:0] d);
    int k;
    model_flush();
    obs_q.delete();
    @(negedge clock);
    cpu_flush = 1'b1; cpu_req = with_req; cpu_write = 1'b1; cpu_address = a; cpu_dataIn = d;
    @(posedge clock);
    @(negedge clock);
    cpu_flush = 1'b0; cpu_req = 1'b0;
    wait_ready(k);
    finish_op(1'b0, 1'b0, k);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; cpu_req = 1'b0; cpu_flush = 1'b0;
    @(posedge clock); #1;
    verifica("rst_outs", 32'({cpu_ready, hit, busy, ram_req, ram_write, cpu_dataOut,
                              ram_address, ram_dataIn}), 32'd0);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    obs_q.delete();
  endtask

  task automatic held_req_test();
    logic exp_hit;
    logic all_hit;
    int   pulses;
    all_hit = 1'b1;
    for (int i = 0; i < 7; i++) begin
      model_access(1'b0, 8'h64, 8'h00, exp_hit);
      all_hit = all_hit & exp_hit;
    end
    obs_q.delete();
    pulses = 0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 8'h64;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == 20) cpu_req = 1'b0;
      if (cpu_ready) begin
        pulses++;
        verifica("held_hit", 32'(hit), 32'(all_hit));
        verifica("held_dout", 32'(cpu_dataOut), 32'(last_rd));
      end
    end
    verifica("held_pulses", 32'(pulses), 32'd7);
    verifica("held_ram", 32'(obs_q.size()), 32'd0);
  endtask

  task automatic reset_mid_wb();
    bit seen;
    do_reset();
    set_mem(8'h65, 8'h07);
    access(1'b1, 8'h65, 8'hAA);
    access(1'b1, 8'h70, 8'h55);
    ack_delay = 12;
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 8'h71;
    @(posedge clock);
    @(negedge clock);
    cpu_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (ram_req) seen = 1'b1;
      else @(negedge clock);
    end
    verifica("wb_seen", 32'(seen), 32'd1);
    verifica("wb_req", 32'({ram_write, ram_address, ram_dataIn}), 32'({1'b1, 8'h65, 8'hAA}));
    do_reset();
    ack_delay = 1;
    access(1'b0, 8'h65, 8'h00);
  endtask

  initial begin : main
    resetn = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_flush = 1'b0;
    cpu_address = 8'h00; cpu_dataIn = 8'h00; ack_delay = 1; spur_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    verifica("por_outs", 32'({cpu_ready, hit, busy, ram_req, ram_write, cpu_dataOut,
                              ram_address, ram_dataIn}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // read miss then hit
    set_mem(8'h64, 8'h05);
    access(1'b0, 8'h64, 8'h00);
    access(1'b0, 8'h64, 8'h00);

    // write miss allocates without fetching
    do_reset();
    access(1'b1, 8'h65, 8'h3C);
    access(1'b0, 8'h65, 8'h00);

    // dirty victim eviction
    do_reset();
    access(1'b0, 8'h64, 8'h00);
    access(1'b1, 8'h65, 8'hAA);
    access(1'b0, 8'h64, 8'h00);
    set_mem(8'h66, 8'h01);
    access(1'b0, 8'h66, 8'h00);

    // flush, repeated flush, flush beating a simultaneous request
    do_reset();
    access(1'b0, 8'h64, 8'h00);
    access(1'b1, 8'h65, 8'hAA);
    flush_op(1'b0, 8'h00, 8'h00);
    flush_op(1'b0, 8'h00, 8'h00);
    access(1'b0, 8'h65, 8'h00);
    flush_op(1'b1, 8'h80, 8'h11);
    access(1'b0, 8'h80, 8'h00);

    // held request: one acceptance per IDLE visit
    access(1'b0, 8'h64, 8'h00);
    held_req_test();

    // slow RAM
    ack_delay = 5;
    access(1'b1, 8'h91, 8'h22);
    access(1'b1, 8'h93, 8'h44);
    access(1'b0, 8'h92, 8'h00);
    ack_delay = 1;

    reset_mid_wb();

    // randomized traffic
    spur_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int op;
      ack_delay = $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op == 0) flush_op(1'($urandom_range(0, 1)), 8'h60 + 8'($urandom_range(0, 5)), 8'($urandom));
      else access(op < 5, 8'h60 + 8'($urandom_range(0, 5)), 8'($urandom));
    end
    spur_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controlador_cache.md
# controlador_cache

Controller for the two-level memory hierarchy: an 8-bit-address, 8-bit-word, 2-line fully associative write-back L1 with single-bit LRU. It sits between a requester (board switches or CPU stub) and the RAM block. It accepts one request at a time, resolves hit or miss, sequences write-back of dirty victims and line fills over a req/ack RAM port, and supports a flush command. Line size equals one word, so a write miss allocates without fetching.

## Interface
- ADDR_W, 8, address width (tag = full address)
- DATA_W, 8, word width
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_write  in  1  1 = write, 0 = read; latched with cpu_req
- cpu_flush  in  1  flush command, sampled only in IDLE, priority over cpu_req
- cpu_address  in  ADDR_W  request address
- cpu_dataIn  in  DATA_W  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_dataOut  out  DATA_W  read data, valid with cpu_ready, held until next completion
- hit  out  1  1 = request hit in L1, valid with cpu_ready (0 for flush)
- busy  out  1  high in every state except IDLE
- ram_req  out  1  RAM transaction request
- ram_write  out  1  1 = RAM write, 0 = RAM read
- ram_address  out  ADDR_W  RAM address
- ram_dataIn  out  DATA_W  data to RAM
- ram_dataOut  in  DATA_W  data from RAM, valid when ram_ack = 1
- ram_ack  in  1  RAM completion, one cycle

## Operation
- Line state: valid, dirty, tag[ADDR_W], data[DATA_W] for each of 2 lines. Register lru holds the index of the least recently used line.
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
- IDLE: cpu_flush=1 leads to FLUSH_SCAN with index 0. Otherwise cpu_req=1 latches write/address/data and goes to LOOKUP.
- LOOKUP: a hit is a valid line with tag == address.
  - Read hit: cpu_dataOut = data.
  - Write hit: data = dataIn, dirty = 1.
  - Both hit cases then go to RESPOND with hit=1.
- Miss victim selection: the lowest-index invalid line, else line lru.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: a write miss installs directly and goes to RESPOND; a read miss goes to FILL.
- WRITEBACK: ram_req=1, ram_write=1, ram_address = victim tag, ram_dataIn = victim data. On ram_ack, clear the victim's dirty bit. Then a write miss installs and goes to RESPOND; a read miss goes to FILL.
- FILL: ram_req=1, ram_write=0, ram_address = latched address. On ram_ack, install ram_dataOut (valid=1, dirty=0), set cpu_dataOut, go to RESPOND.
- Write-miss install: valid=1, dirty=1, tag = address, data = dataIn.
- Every completed access makes the touched line MRU (lru = the other index).
- RESPOND: cpu_ready=1 for one cycle, hit=0 on miss. Return to IDLE.
- Flush sequence:
  - FLUSH_SCAN: if the line at the current index is valid and dirty, go to FLUSH_WB. Otherwise advance the index. After index 1, go to RESPOND with hit=0.
  - FLUSH_WB: write back that line, clear dirty on ram_ack, return to FLUSH_SCAN at the next index.
  - Flush never changes valid or lru.
- Duplicate tags cannot arise, because installs happen only on a miss.

## Timing
- Reset (resetn=0 at a rising edge): state IDLE, both lines valid=0 and dirty=0, lru=0, all outputs 0.
- Reset mid-operation: the same edge aborts the transaction. ram_req is 0 from that edge, dirty contents are discarded, and no cpu_ready is issued.
- Hit latency: request accepted at edge N, LOOKUP at N+1, cpu_ready high in the cycle after edge N+2 (2 cycles).
- Miss latency: hit latency plus, for each RAM transaction, the cycles until ram_ack plus one.
- ram_req, ram_write, ram_address and ram_dataIn are held stable from assertion until ram_ack is sampled high. ram_req drops at the next edge.
- ram_ack while ram_req=0 is ignored.
- cpu_* inputs are ignored while busy=1. A held cpu_req is re-accepted only on the IDLE cycle following RESPOND.
- cpu_req and cpu_flush high together in IDLE: the flush is taken and the request is dropped.

## Structure
- Package controlador_cache_pkg holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - line struct {valid, dirty, tag, data};
  - NUM_LINES = 2.
- Sub-module linhas_cache holds the 2-line store and the lru register. It provides combinational lookup (hit, hit_idx, victim_idx) and registered update ports. The FSM stays in controlador_cache.

## Test plan
- Reset, then read 0x64 with RAM returning 0x05: exactly one RAM read of 0x64, cpu_dataOut=0x05, hit=0. Re-read 0x64: hit=1, cpu_ready 2 cycles after acceptance, no ram_req.
- Write 0x65=0x3C after reset: no RAM traffic, hit=0. Read 0x65: 0x3C, hit=1.
- Eviction of a dirty victim:
  - Setup: read 0x64, write 0x65=0xAA, then read 0x64 (0x65 becomes LRU).
  - Stimulus: read 0x66 (RAM data 0x01).
  - Required: RAM write 0x65/0xAA, then RAM read 0x66, cpu_dataOut=0x01, hit=0.
- Flush with line 1 dirty (0x65=0xAA): exactly one RAM write 0x65/0xAA, one cpu_ready with hit=0. A second flush produces no RAM traffic. A following read of 0x65 hits.
- Delayed ack and reset:
  - ram_ack delayed 5 cycles: RAM outputs stay stable throughout.
  - resetn=0 mid-WRITEBACK: all outputs 0 at the next edge, and a subsequent read of 0x65 misses.
- cpu_req held high for 20 cycles (read 0x64, hit): one acceptance per IDLE visit. cpu_flush with cpu_req in IDLE: only the flush executes.
